int_rti_sequencer: RTL and testbench
====================================

Name: int_rti_sequencer

Overview:
- Sequences interrupt entry and RTI return for the five-stage pipeline.
- Stalls fetch and flushes FD/DE, then waits for the memory stage to drain.
- Takes the stack/memory port to push {PC[31:16], PC[15:0], flags} on entry and pop them in reverse on RTI.
- On entry, redirects fetch to the 32-bit vector stored at VEC_ADDR.

Parameters:
- VEC_ADDR, 16'h0000, word address of the vector low half; the high half is at VEC_ADDR+1.
- FLAG_W, 3, width of the flag register.

Ports:
- clk  in  1  system clock (rising edge)
- reset  in  1  synchronous, active-high
- int_req  in  1  external interrupt; a one-cycle pulse is sufficient
- rti_ex  in  1  RTI decoded in execute stage
- pc_resume  in  32  return PC, sampled when leaving IDLE
- flags_in  in  FLAG_W  current flag register
- mem_stage_busy  in  1  pipeline memory stage holds a valid memory op
- mem_rdata  in  16  memory read data, valid the cycle after a read/pop issue
- stall_fetch  out  1  hold PC and FD buffer
- flush_fd  out  1  flush FD buffer
- flush_de  out  1  flush DE buffer
- seq_mem_grant  out  1  memory port owned by sequencer; the pipeline mem op is masked
- seq_push  out  1  push seq_wdata (SP decrement handled by memory stage)
- seq_pop  out  1  pop a word
- seq_rd  out  1  plain read at seq_addr
- seq_addr  out  16  address for seq_rd
- seq_wdata  out  16  push data
- pc_load  out  1  one-cycle fetch redirect
- pc_load_val  out  32  redirect target
- flags_load  out  1  one-cycle flag register overwrite
- flags_out  out  FLAG_W  restored flags
- int_ack  out  1  one-cycle pulse when the handler PC is loaded
- in_handler  out  1  handler active (interrupt masking)

Behaviour:
- Reset: state=IDLE; pending, in_handler, pc_hold, flag_hold and lo_hold are cleared; all outputs are 0.
- pending: set on int_req=1 and cleared on exit from IDLE into the INT path. A pulse arriving while busy or while in_handler=1 is retained.
- IDLE exit priority: rti_ex over pending.
  - rti_ex=1 → R_DRAIN.
  - pending=1 with in_handler=0 → I_DRAIN; latch pc_hold=pc_resume and flag_hold=flags_in.
  - No nesting.
- Entry cycle (the IDLE→drain transition, registered): flush_fd=flush_de=1 for exactly one cycle.
- stall_fetch=1 in every state except IDLE. It also stays high in the cycle pc_load is asserted.
- I_DRAIN / R_DRAIN: hold while mem_stage_busy=1, with no timeout. The next state follows when mem_stage_busy=0.
- seq_mem_grant=1 in every state after drain. seq_push, seq_pop and seq_rd are mutually exclusive, at most one per cycle.
- INT path, one state per cycle:
  - PUSH_H: seq_push, seq_wdata=pc_hold[31:16].
  - PUSH_L: seq_push, seq_wdata=pc_hold[15:0].
  - PUSH_F: seq_push, seq_wdata={zero-pad, flag_hold}.
  - VEC0: seq_rd, seq_addr=VEC_ADDR.
  - VEC1: seq_rd, seq_addr=VEC_ADDR+1 (16-bit wrap); capture lo_hold=mem_rdata.
  - I_LOAD: pc_load=1, pc_load_val={mem_rdata, lo_hold}, int_ack=1; in_handler←1; → IDLE.
- RTI path:
  - POP_F: seq_pop.
  - POP_L: seq_pop; capture flag_hold=mem_rdata[FLAG_W-1:0].
  - POP_H: seq_pop; capture lo_hold=mem_rdata.
  - R_LOAD: pc_load=1, pc_load_val={mem_rdata, lo_hold}, flags_load=1, flags_out=flag_hold; in_handler←0; → IDLE.
- rti_ex while in_handler=0 is still executed (stack underflow is the memory stage's concern).
- Latency: INT with no drain wait is 1 (I_DRAIN) + 5 + 1 = 7 cycles from leaving IDLE to pc_load. RTI is 1 + 3 + 1 = 5 cycles.
- After an RTI returns to IDLE with pending=1, INT entry begins on the next cycle.
- int_req in the same cycle as I_LOAD sets pending; it is serviced only after the next RTI.
- rti_ex while not IDLE is ignored; the pipeline is stalled and flushed.
- Reset mid-sequence: IDLE next cycle; no pc_load or flags_load is issued; partially pushed words are abandoned.

Decomposition:
- Shared package: state enum (IDLE, I_DRAIN, PUSH_H, PUSH_L, PUSH_F, VEC0, VEC1, I_LOAD, R_DRAIN, POP_F, POP_L, POP_H, R_LOAD), VEC_ADDR default, FLAG_W.
- Single module with no sub-module. The next-state/output decode is one combinational block beside the state and hold registers.

Test Plan:
- Int, idle pipe: pc_resume=32'h0001_0040, flags=3'b101, vector M[0]=16'h0200, M[1]=16'h0000 → flush pulse at cycle 1; pushes 16'h0001, 16'h0040, 16'h0005; pc_load_val=32'h0000_0200 with int_ack at cycle 7; in_handler=1.
- Drain: mem_stage_busy=1 for 3 cycles after int → zero seq_* activity until busy drops; pc_load 3 cycles later than the idle case.
- RTI: pops return 16'h0005, 16'h0040, 16'h0001 → pc_load_val=32'h0001_0040, flags_out=3'b101, flags_load=1 in the same cycle; in_handler=0.
- Int during handler: int_req pulse while in_handler=1 → no action; after R_LOAD, INT entry starts the next cycle.
- Simultaneous int_req and rti_ex in IDLE with in_handler=1 → RTI runs first, then the interrupt is taken.
- Reset asserted in PUSH_L → IDLE next cycle; all outputs 0; a subsequent int completes normally.

Source files
------------

// File: rtl/int_rti_sequencer_pkg.sv
// Shared types and defaults for the interrupt entry / RTI return sequencer.
package int_rti_sequencer_pkg;

    localparam logic [15:0] VecAddrDefault = 16'h0000;
    localparam int unsigned FlagWDefault   = 3;

    typedef enum logic [3:0] {
        StIdle,
        StIDrain,
        StPushH,
        StPushL,
        StPushF,
        StVec0,
        StVec1,
        StILoad,
        StRDrain,
        StPopF,
        StPopL,
        StPopH,
        StRLoad
    } seq_state_e;

    // The memory port belongs to the sequencer once the pipeline memory stage has drained.
    function automatic logic is_mem_owner(seq_state_e s);
        return !(s inside {StIdle, StIDrain, StRDrain});
    endfunction

endpackage

// File: rtl/int_rti_sequencer_if.sv
// Pipeline-facing signals of the interrupt sequencer; slave is the sequencer side.
interface int_rti_sequencer_if
    import int_rti_sequencer_pkg::*;
#(
    parameter int unsigned FLAG_W = FlagWDefault
) ();

    logic              int_req;
    logic              rti_ex;
    logic [31:0]       pc_resume;
    logic [FLAG_W-1:0] flags_in;
    logic              mem_stage_busy;
    logic [15:0]       mem_rdata;

    logic              stall_fetch;
    logic              flush_fd;
    logic              flush_de;
    logic              seq_mem_grant;
    logic              seq_push;
    logic              seq_pop;
    logic              seq_rd;
    logic [15:0]       seq_addr;
    logic [15:0]       seq_wdata;
    logic              pc_load;
    logic [31:0]       pc_load_val;
    logic              flags_load;
    logic [FLAG_W-1:0] flags_out;
    logic              int_ack;
    logic              in_handler;

    modport master (
        output int_req, rti_ex, pc_resume, flags_in, mem_stage_busy, mem_rdata,
        input  stall_fetch, flush_fd, flush_de, seq_mem_grant, seq_push, seq_pop, seq_rd,
        input  seq_addr, seq_wdata, pc_load, pc_load_val, flags_load, flags_out, int_ack,
        input  in_handler
    );

    modport slave (
        input  int_req, rti_ex, pc_resume, flags_in, mem_stage_busy, mem_rdata,
        output stall_fetch, flush_fd, flush_de, seq_mem_grant, seq_push, seq_pop, seq_rd,
        output seq_addr, seq_wdata, pc_load, pc_load_val, flags_load, flags_out, int_ack,
        output in_handler
    );

endinterface

// File: rtl/int_rti_sequencer.sv
// Interrupt entry / RTI return sequencer: drains the pipe, pushes or pops {PC hi, PC lo, flags}
// over the stack port and redirects fetch.
module int_rti_sequencer
    import int_rti_sequencer_pkg::*;
#(
    parameter logic [15:0] VEC_ADDR = VecAddrDefault,
    parameter int unsigned FLAG_W   = FlagWDefault
) (
    input logic                clk,
    input logic                reset,
    int_rti_sequencer_if.slave bus
);

    seq_state_e        state_q, state_d;
    logic              pending_q, pending_d;
    logic              in_handler_q, in_handler_d;
    logic [31:0]       pc_hold_q, pc_hold_d;
    logic [FLAG_W-1:0] flag_hold_q, flag_hold_d;
    logic [15:0]       lo_hold_q, lo_hold_d;

    logic              stall_q, stall_d;
    logic              flush_q, flush_d;
    logic              grant_q, grant_d;
    logic              push_q, push_d;
    logic              pop_q, pop_d;
    logic              rd_q, rd_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              pc_load_q, pc_load_d;
    logic              flags_load_q, flags_load_d;
    logic [FLAG_W-1:0] flags_out_q, flags_out_d;
    logic              int_ack_q, int_ack_d;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | bus.int_req;
        in_handler_d = in_handler_q;
        pc_hold_d    = pc_hold_q;
        flag_hold_d  = flag_hold_q;
        lo_hold_d    = lo_hold_q;

        unique case (state_q)
            StIdle: begin
                if (bus.rti_ex) begin
                    state_d = StRDrain;
                end else if ((pending_q || bus.int_req) && !in_handler_q) begin
                    state_d     = StIDrain;
                    pending_d   = 1'b0;
                    pc_hold_d   = bus.pc_resume;
                    flag_hold_d = bus.flags_in;
                end
            end
            StIDrain: if (!bus.mem_stage_busy) state_d = StPushH;
            StPushH:  state_d = StPushL;
            StPushL:  state_d = StPushF;
            StPushF:  state_d = StVec0;
            StVec0:   state_d = StVec1;
            StVec1: begin
                state_d   = StILoad;
                lo_hold_d = bus.mem_rdata;
            end
            StILoad: begin
                state_d      = StIdle;
                in_handler_d = 1'b1;
            end
            StRDrain: if (!bus.mem_stage_busy) state_d = StPopF;
            StPopF:   state_d = StPopL;
            StPopL: begin
                state_d     = StPopH;
                flag_hold_d = bus.mem_rdata[FLAG_W-1:0];
            end
            StPopH: begin
                state_d   = StRLoad;
                lo_hold_d = bus.mem_rdata;
            end
            StRLoad: begin
                state_d      = StIdle;
                in_handler_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        stall_d      = (state_d != StIdle);
        flush_d      = (state_q == StIdle) && (state_d != StIdle);
        grant_d      = is_mem_owner(state_d);
        push_d       = state_d inside {StPushH, StPushL, StPushF};
        pop_d        = state_d inside {StPopF, StPopL, StPopH};
        rd_d         = state_d inside {StVec0, StVec1};
        pc_load_d    = state_d inside {StILoad, StRLoad};
        int_ack_d    = (state_d == StILoad);
        flags_load_d = (state_d == StRLoad);

        wdata_d     = '0;
        addr_d      = '0;
        flags_out_d = '0;
        case (state_d)
            StPushH: wdata_d = pc_hold_q[31:16];
            StPushL: wdata_d = pc_hold_q[15:0];
            StPushF: wdata_d = 16'(flag_hold_q);
            StVec0:  addr_d = VEC_ADDR;
            StVec1:  addr_d = VEC_ADDR + 16'd1;
            StRLoad: flags_out_d = flag_hold_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            pending_q    <= 1'b0;
            in_handler_q <= 1'b0;
            pc_hold_q    <= '0;
            flag_hold_q  <= '0;
            lo_hold_q    <= '0;
            stall_q      <= 1'b0;
            flush_q      <= 1'b0;
            grant_q      <= 1'b0;
            push_q       <= 1'b0;
            pop_q        <= 1'b0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pc_load_q    <= 1'b0;
            flags_load_q <= 1'b0;
            flags_out_q  <= '0;
            int_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            in_handler_q <= in_handler_d;
            pc_hold_q    <= pc_hold_d;
            flag_hold_q  <= flag_hold_d;
            lo_hold_q    <= lo_hold_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
            grant_q      <= grant_d;
            push_q       <= push_d;
            pop_q        <= pop_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pc_load_q    <= pc_load_d;
            flags_load_q <= flags_load_d;
            flags_out_q  <= flags_out_d;
            int_ack_q    <= int_ack_d;
        end
    end

    assign bus.stall_fetch   = stall_q;
    assign bus.flush_fd      = flush_q;
    assign bus.flush_de      = flush_q;
    assign bus.seq_mem_grant = grant_q;
    assign bus.seq_push      = push_q;
    assign bus.seq_pop       = pop_q;
    assign bus.seq_rd        = rd_q;
    assign bus.seq_addr      = addr_q;
    assign bus.seq_wdata     = wdata_q;
    assign bus.pc_load       = pc_load_q;
    // High half arrives on mem_rdata in the load cycle itself.
    assign bus.pc_load_val   = pc_load_q ? {bus.mem_rdata, lo_hold_q} : 32'h0;
    assign bus.flags_load    = flags_load_q;
    assign bus.flags_out     = flags_out_q;
    assign bus.int_ack       = int_ack_q;
    assign bus.in_handler    = in_handler_q;

endmodule

// File: tb/tb_int_rti_sequencer.sv
// Bench for int_rti_sequencer: stack/vector memory model plus push and pc_load scoreboards.
module tb_int_rti_sequencer;

    typedef struct packed {
        logic [31:0] val;
        logic        ack;
        logic        fload;
        logic [2:0]  fl;
    } load_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mem [0:15];
    logic [15:0] stack[$];
    logic [15:0] exp_push[$];
    load_t       exp_load[$];
    logic [15:0] rdata_nxt = 16'h0;

    always #5 clk = ~clk;

    int_rti_sequencer_if #(.FLAG_W(3)) bus ();

    int_rti_sequencer #(
        .VEC_ADDR(16'h0000),
        .FLAG_W  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [77:0] all_outs();
        return {bus.stall_fetch, bus.flush_fd, bus.flush_de, bus.seq_mem_grant, bus.seq_push,
                bus.seq_pop, bus.seq_rd, bus.seq_addr, bus.seq_wdata, bus.pc_load,
                bus.pc_load_val, bus.flags_load, bus.flags_out, bus.int_ack, bus.in_handler};
    endfunction

    // Read data appears the cycle after a pop/read issue.
    always @(posedge clk) begin
        #1;
        bus.mem_rdata = rdata_nxt;
    end

    // Memory model and scoreboards, sampled mid-cycle.
    always @(negedge clk) begin
        logic [15:0] w;
        load_t       e;
        if (bus.seq_push || bus.seq_pop || bus.seq_rd) begin
            checks++;
            if ((int'(bus.seq_push) + int'(bus.seq_pop) + int'(bus.seq_rd)) != 1
                || bus.seq_mem_grant !== 1'b1) begin
                errors++;
                $display("FAIL mem_port_excl: push=%b pop=%b rd=%b grant=%b, required one op with grant",
                         bus.seq_push, bus.seq_pop, bus.seq_rd, bus.seq_mem_grant);
            end
        end
        if (bus.seq_push) begin
            checks++;
            if (exp_push.size() == 0) begin
                errors++;
                $display("FAIL push_unexpected: wdata=%h, required no push", bus.seq_wdata);
            end else begin
                w = exp_push.pop_front();
                if (bus.seq_wdata !== w) begin
                    errors++;
                    $display("FAIL push_data: wdata=%h, required %h", bus.seq_wdata, w);
                end
            end
            stack.push_back(bus.seq_wdata);
        end
        if (bus.seq_pop) begin
            if (stack.size() > 0) rdata_nxt = stack.pop_back();
            else rdata_nxt = 16'hDEAD;
        end
        if (bus.seq_rd) rdata_nxt = mem[bus.seq_addr[3:0]];
        if (bus.pc_load) begin
            checks++;
            if (exp_load.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected: pc_load_val=%h, required no pc_load", bus.pc_load_val);
            end else begin
                e = exp_load.pop_front();
                if (bus.pc_load_val !== e.val || bus.int_ack !== e.ack
                    || bus.flags_load !== e.fload || bus.flags_out !== e.fl) begin
                    errors++;
                    $display("FAIL load: val=%h ack=%b fload=%b flags=%b, required %h %b %b %b",
                             bus.pc_load_val, bus.int_ack, bus.flags_load, bus.flags_out,
                             e.val, e.ack, e.fload, e.fl);
                end
            end
        end else if (bus.int_ack || bus.flags_load) begin
            checks++;
            errors++;
            $display("FAIL strobe_without_load: int_ack=%b flags_load=%b, required 0 0",
                     bus.int_ack, bus.flags_load);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle index of the next pc_load (at its negedge), or -1 on timeout.
    task automatic wait_pc_load(input int start, output int at);
        at = -1;
        for (int i = start; i < start + 40; i++) begin
            @(negedge clk);
            if (bus.pc_load === 1'b1) begin
                at = i;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.int_req = 1'b0;
        bus.rti_ex = 1'b0;
        bus.pc_resume = '0;
        bus.flags_in = '0;
        bus.mem_stage_busy = 1'b0;
        bus.mem_rdata = '0;
        step();
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outs: outs=%h, required 0", all_outs());
        end
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL idle_outs: outs=%h, required 0", all_outs());
        end
        step();
    endtask

    task automatic test_int_entry(input logic [31:0] pc, input logic [2:0] fl,
                                  input logic [15:0] vlo, input logic [15:0] vhi, input int busy_n);
        int at;
        mem[0] = vlo;
        mem[1] = vhi;
        exp_push.push_back(pc[31:16]);
        exp_push.push_back(pc[15:0]);
        exp_push.push_back({13'b0, fl});
        exp_load.push_back('{val: {vhi, vlo}, ack: 1'b1, fload: 1'b0, fl: 3'b000});
        bus.pc_resume = pc;
        bus.flags_in = fl;
        bus.mem_stage_busy = (busy_n > 0);
        bus.int_req = 1'b1;
        step();
        bus.int_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.flush_fd, bus.flush_de, bus.stall_fetch} !== 3'b111) begin
            errors++;
            $display("FAIL int_flush: fd/de/stall=%b%b%b, required 111",
                     bus.flush_fd, bus.flush_de, bus.stall_fetch);
        end
        for (int c = 1; c <= busy_n + 1; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if ({bus.seq_mem_grant, bus.seq_push, bus.seq_pop, bus.seq_rd} !== 4'b0000) begin
                errors++;
                $display("FAIL drain_quiet: cycle %0d grant/push/pop/rd=%b%b%b%b, required 0000", c,
                         bus.seq_mem_grant, bus.seq_push, bus.seq_pop, bus.seq_rd);
            end
            step();
            if (c == busy_n) bus.mem_stage_busy = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({bus.flush_fd, bus.seq_mem_grant, bus.seq_push} !== 3'b011) begin
            errors++;
            $display("FAIL push_start: flush/grant/push=%b%b%b, required 011",
                     bus.flush_fd, bus.seq_mem_grant, bus.seq_push);
        end
        step();
        wait_pc_load(busy_n + 3, at);
        checks++;
        if (at != 7 + busy_n) begin
            errors++;
            $display("FAIL int_latency: pc_load at cycle %0d, required %0d", at, 7 + busy_n);
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus.in_handler, bus.stall_fetch} !== 2'b10) begin
            errors++;
            $display("FAIL int_done: in_handler/stall=%b%b, required 10",
                     bus.in_handler, bus.stall_fetch);
        end
        step();
    endtask

    task automatic test_rti(input logic [31:0] pc, input logic [2:0] fl);
        int at;
        exp_load.push_back('{val: pc, ack: 1'b0, fload: 1'b1, fl: fl});
        bus.rti_ex = 1'b1;
        step();
        bus.rti_ex = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.flush_fd, bus.flush_de, bus.stall_fetch} !== 3'b111) begin
            errors++;
            $display("FAIL rti_flush: fd/de/stall=%b%b%b, required 111",
                     bus.flush_fd, bus.flush_de, bus.stall_fetch);
        end
        step();
        wait_pc_load(2, at);
        checks++;
        if (at != 5) begin
            errors++;
            $display("FAIL rti_latency: pc_load at cycle %0d, required 5", at);
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus.in_handler, bus.stall_fetch} !== 2'b00) begin
            errors++;
            $display("FAIL rti_done: in_handler/stall=%b%b, required 00",
                     bus.in_handler, bus.stall_fetch);
        end
        step();
    endtask

    // Runs an RTI whose pending interrupt is taken straight after R_LOAD.
    task automatic test_int_during_handler(input logic both, input logic [31:0] rpc,
                                           input logic [2:0] rfl, input logic [31:0] npc,
                                           input logic [2:0] nfl);
        int at;
        if (!both) begin
            bus.int_req = 1'b1;
            step();
            bus.int_req = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                checks++;
                if ({bus.stall_fetch, bus.flush_fd} !== 2'b00) begin
                    errors++;
                    $display("FAIL masked_int: cycle %0d stall/flush=%b%b, required 00", c,
                             bus.stall_fetch, bus.flush_fd);
                end
                step();
            end
        end
        exp_load.push_back('{val: rpc, ack: 1'b0, fload: 1'b1, fl: rfl});
        exp_push.push_back(npc[31:16]);
        exp_push.push_back(npc[15:0]);
        exp_push.push_back({13'b0, nfl});
        exp_load.push_back('{val: {mem[1], mem[0]}, ack: 1'b1, fload: 1'b0, fl: 3'b000});
        bus.pc_resume = npc;
        bus.flags_in = nfl;
        bus.rti_ex = 1'b1;
        if (both) bus.int_req = 1'b1;
        step();
        bus.rti_ex = 1'b0;
        bus.int_req = 1'b0;
        wait_pc_load(1, at);
        checks++;
        if (at != 5 || bus.flags_load !== 1'b1) begin
            errors++;
            $display("FAIL rti_first: pc_load at %0d flags_load=%b, required 5 1", at, bus.flags_load);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.stall_fetch !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle: stall=%b, required 0", bus.stall_fetch);
        end
        step();
        @(negedge clk);
        checks++;
        if ({bus.flush_fd, bus.stall_fetch} !== 2'b11) begin
            errors++;
            $display("FAIL pend_entry: flush/stall=%b%b, required 11", bus.flush_fd, bus.stall_fetch);
        end
        step();
        wait_pc_load(8, at);
        checks++;
        if (at != 13 || bus.int_ack !== 1'b1) begin
            errors++;
            $display("FAIL pend_load: pc_load at %0d int_ack=%b, required 13 1", at, bus.int_ack);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.in_handler !== 1'b1) begin
            errors++;
            $display("FAIL pend_handler: in_handler=%b, required 1", bus.in_handler);
        end
        step();
    endtask

    task automatic test_reset_mid(input logic [31:0] pc, input logic [2:0] fl);
        exp_push.push_back(pc[31:16]);
        exp_push.push_back(pc[15:0]);
        bus.pc_resume = pc;
        bus.flags_in = fl;
        bus.int_req = 1'b1;
        step();
        bus.int_req = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({bus.seq_push, bus.seq_wdata} !== {1'b1, pc[15:0]}) begin
            errors++;
            $display("FAIL push_l_cycle: push=%b wdata=%h, required 1 %h",
                     bus.seq_push, bus.seq_wdata, pc[15:0]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        stack.delete();
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL mid_reset_outs: outs=%h, required 0", all_outs());
        end
        checks++;
        if (exp_push.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_pushes: %0d pushes outstanding, required 0", exp_push.size());
        end
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.stall_fetch !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: stall=%b, required 0", bus.stall_fetch);
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h0101);
        test_reset();
        test_int_entry(32'h0001_0040, 3'b101, 16'h0200, 16'h0000, 0);
        test_rti(32'h0001_0040, 3'b101);
        test_int_entry(32'h1234_5678, 3'b010, 16'hBEEF, 16'h00AB, 3);
        test_int_during_handler(1'b0, 32'h1234_5678, 3'b010, 32'h0000_0ABC, 3'b110);
        test_int_during_handler(1'b1, 32'h0000_0ABC, 3'b110, 32'h0000_1000, 3'b001);
        test_rti(32'h0000_1000, 3'b001);
        test_reset_mid(32'h5555_AAAA, 3'b111);
        test_int_entry(32'h0000_7777, 3'b100, 16'h4000, 16'h0008, 0);
        test_rti(32'h0000_7777, 3'b100);
        checks++;
        if (exp_push.size() != 0 || exp_load.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pushes %0d loads outstanding, required 0 0",
                     exp_push.size(), exp_load.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
